morphle_conf_loader: RTL and testbench

Wishbone-slave configuration loader for a Morphle Logic `yblock`. Wishbone writes are turned into timed `cbitin`/`confclk` sequences, so the RISC-V can shift configuration rows into the cell array without bit-banging logic-analyzer pins. The loader also drives `uin` and the array reset, and samples `uout` and `cbitout`. It sits in the user project wrapper between the Wishbone port and the `yblock` instance.

---
 rtl/morphle_pkg.sv | 43 ++++
 rtl/morphle_conf_fifo.sv | 89 ++++++++
 rtl/morphle_conf_loader.sv | 186 ++++++++++++++++++
 tb/tb_morphle_conf_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/morphle_pkg.sv
// Shared definitions for the Morphle yblock configuration loader.
// MORPHLE_CONF_QUEUE_EN selects a 4-deep word queue; otherwise a single holding register.
package morphle_pkg;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_CONF   = 3'd1;
  localparam logic [2:0] OFF_STATUS = 3'd2;
  localparam logic [2:0] OFF_UIN    = 3'd3;
  localparam logic [2:0] OFF_UOUT   = 3'd4;
  localparam logic [2:0] OFF_CAPT   = 3'd5;

  localparam int unsigned STAT_BUSY     = 0;
  localparam int unsigned STAT_DONE     = 1;
  localparam int unsigned STAT_OVF      = 2;
  localparam int unsigned STAT_CNT_LSB  = 4;
  localparam int unsigned STAT_ROWS_LSB = 8;

`ifdef MORPHLE_CONF_QUEUE_EN
  localparam int unsigned QUEUE_DEPTH = 4;
`else
  localparam int unsigned QUEUE_DEPTH = 1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Replace the byte lanes of old_v selected by sel with those of new_v.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] v;
    v = old_v;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) v[8*i +: 8] = new_v[8*i +: 8];
    end
    return v;
  endfunction

endpackage

// File: rtl/morphle_conf_fifo.sv
// Word queue feeding the shift FSM: circular FIFO with MORPHLE_CONF_QUEUE_EN,
// otherwise a single holding register. A push while full is dropped.
module morphle_conf_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head_c,
  output logic             o_full_c,
  output logic             o_empty_c,
  output logic [CW-1:0]    o_count
);

`ifdef MORPHLE_CONF_QUEUE_EN
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_full_c  = (r_cnt == CW'(DEPTH));
  assign o_empty_c = (r_cnt == '0);
  assign o_count   = r_cnt;
  assign o_head_c  = r_mem[r_rptr];
  assign w_do_push = i_push & ~o_full_c;
  assign w_do_pop  = i_pop & ~o_empty_c;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) r_wptr <= ptr_inc(r_wptr);
      if (w_do_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush && !i_rst) r_mem[r_wptr] <= i_data;
  end
`else
  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  assign o_full_c  = (CW'(r_valid) == CW'(DEPTH));
  assign o_empty_c = ~r_valid;
  assign o_count   = CW'(r_valid);
  assign o_head_c  = r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_pop && r_valid) begin
      r_valid <= 1'b0;
    end else if (i_push && !r_valid) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end
`endif

endmodule

// File: rtl/morphle_conf_loader.sv
// Wishbone slave turning CONF writes into timed cbitin/confclk row shifts for a yblock.
// Build option: MORPHLE_CONF_QUEUE_EN (4-entry word queue instead of one holding register).
module morphle_conf_loader
  import morphle_pkg::*;
#(
  parameter int unsigned BLOCKWIDTH  = 16,
  parameter int unsigned BLOCKHEIGHT = 16,
  parameter int unsigned PHASE       = 2
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_dat_i,
  input  logic [31:0]             wbs_adr_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic                    reset,
  output logic                    confclk,
  output logic [BLOCKWIDTH-1:0]   cbitin,
  input  logic [BLOCKWIDTH-1:0]   cbitout,
  output logic [2*BLOCKWIDTH-1:0] uin,
  input  logic [2*BLOCKWIDTH-1:0] uout
);

  localparam int unsigned UW = 2 * BLOCKWIDTH;
  localparam int unsigned RW = $clog2(BLOCKHEIGHT + 1);
  localparam int unsigned TW = 4;
  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);

  state_e                r_state;
  state_e                w_next;
  logic [TW-1:0]         r_tmr;
  logic                  r_ack;
  logic [31:0]           r_dat;
  logic                  r_ctrl;
  logic                  r_abort;
  logic                  r_confclk;
  logic                  r_done;
  logic                  r_ovf;
  logic [BLOCKWIDTH-1:0] r_cbitin;
  logic [BLOCKWIDTH-1:0] r_capt;
  logic [UW-1:0]         r_uin;
  logic [RW-1:0]         r_rows;

  logic                  w_acc;
  logic                  w_wr;
  logic                  w_rd;
  logic [2:0]            w_off;
  logic                  w_ctrl_wr;
  logic                  w_conf_wr;
  logic                  w_stat_wr;
  logic                  w_uin_wr;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_tmr_last;
  logic                  w_row_done;
  logic                  w_busy;
  logic [BLOCKWIDTH-1:0] w_head;
  logic [CW-1:0]         w_cnt;
  logic [31:0]           w_rdata;
  logic                  w_unused_adr;

  assign w_acc     = wbs_cyc_i & wbs_stb_i & ~r_ack;
  assign w_wr      = w_acc & wbs_we_i;
  assign w_rd      = w_acc & ~wbs_we_i;
  assign w_off     = wbs_adr_i[4:2];
  assign w_ctrl_wr = w_wr & (w_off == OFF_CTRL);
  assign w_conf_wr = w_wr & (w_off == OFF_CONF);
  assign w_stat_wr = w_wr & (w_off == OFF_STATUS);
  assign w_uin_wr  = w_wr & (w_off == OFF_UIN);
  assign w_unused_adr = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

  assign w_tmr_last = (r_tmr == TW'(PHASE - 1));
  assign w_row_done = (r_state == ST_HOLD) & w_tmr_last & ~r_abort;
  assign w_busy     = (r_state != ST_IDLE) | ~w_empty;

  morphle_conf_fifo #(
    .WIDTH (BLOCKWIDTH),
    .DEPTH (QUEUE_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .i_clk     (wb_clk_i),
    .i_rst     (wb_rst_i),
    .i_push    (w_conf_wr),
    .i_pop     (w_pop),
    .i_flush   (r_abort),
    .i_data    (BLOCKWIDTH'(wbs_dat_i[15:0])),
    .o_head_c  (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_count   (w_cnt)
  );

  // Shift FSM next state; an abort wins over every phase transition.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    if (r_abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty && !r_ctrl) begin
            w_next = ST_SETUP;
            w_pop  = 1'b1;
          end
        end
        ST_SETUP: if (w_tmr_last) w_next = ST_HIGH;
        ST_HIGH:  if (w_tmr_last) w_next = ST_HOLD;
        ST_HOLD:  if (w_tmr_last) w_next = ST_IDLE;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_CTRL:   w_rdata[0] = r_ctrl;
      OFF_STATUS: begin
        w_rdata[STAT_BUSY]               = w_busy;
        w_rdata[STAT_DONE]               = r_done;
        w_rdata[STAT_OVF]                = r_ovf;
        w_rdata[STAT_CNT_LSB +: 4]       = 4'(w_cnt);
        w_rdata[STAT_ROWS_LSB +: 5]      = 5'(r_rows);
      end
      OFF_UIN:    w_rdata = 32'(r_uin);
      OFF_UOUT:   w_rdata = 32'(uout);
      OFF_CAPT:   w_rdata = 32'(r_capt);
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= ST_IDLE;
      r_tmr     <= '0;
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_ctrl    <= 1'b1;
      r_abort   <= 1'b0;
      r_confclk <= 1'b0;
      r_cbitin  <= '0;
      r_capt    <= '0;
      r_uin     <= '0;
      r_rows    <= '0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_ack   <= w_acc;
      r_dat   <= w_rd ? w_rdata : '0;
      r_abort <= w_ctrl_wr & wbs_sel_i[0] & wbs_dat_i[0];
      if (w_ctrl_wr && wbs_sel_i[0]) r_ctrl <= wbs_dat_i[0];
      if (w_uin_wr) r_uin <= UW'(byte_merge(32'(r_uin), wbs_dat_i, wbs_sel_i));

      r_state   <= w_next;
      r_tmr     <= (w_next == r_state && r_state != ST_IDLE) ? r_tmr + TW'(1) : '0;
      r_confclk <= (w_next == ST_HIGH);
      if (w_pop) r_cbitin <= w_head;
      if (r_state == ST_SETUP && w_next == ST_HIGH) r_capt <= cbitout;

      // STATUS writes clear the sticky flags and the row count.
      if (w_stat_wr) begin
        r_rows <= '0;
        r_done <= 1'b0;
        r_ovf  <= 1'b0;
      end else begin
        if (w_row_done && r_rows != RW'(BLOCKHEIGHT)) r_rows <= r_rows + RW'(1);
        if (w_row_done && r_rows == RW'(BLOCKHEIGHT - 1)) r_done <= 1'b1;
        if (w_conf_wr && w_full) r_ovf <= 1'b1;
      end
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign reset     = r_ctrl;
  assign confclk   = r_confclk;
  assign cbitin    = r_cbitin;
  assign uin       = r_uin;

endmodule

// File: tb/tb_morphle_conf_loader.sv
// Directed self-checking bench for morphle_conf_loader with a 16-row yblock chain stub.
module tb_morphle_conf_loader;
  import morphle_pkg::*;

  localparam int BW = 16;
  localparam int BH = 16;
  localparam int PH = 2;

  logic          clk = 1'b0;
  logic          wb_rst_i;
  logic          wbs_stb_i;
  logic          wbs_cyc_i;
  logic          wbs_we_i;
  logic [3:0]    wbs_sel_i;
  logic [31:0]   wbs_dat_i;
  logic [31:0]   wbs_adr_i;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;
  logic          reset;
  logic          confclk;
  logic [BW-1:0] cbitin;
  logic [BW-1:0] cbitout;
  logic [2*BW-1:0] uin;
  logic [2*BW-1:0] uout;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  morphle_conf_loader #(
    .BLOCKWIDTH  (BW),
    .BLOCKHEIGHT (BH),
    .PHASE       (PH)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (wb_rst_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .reset     (reset),
    .confclk   (confclk),
    .cbitin    (cbitin),
    .cbitout   (cbitout),
    .uin       (uin),
    .uout      (uout)
  );

  // Stub configuration chain: a row emerges BH confclk pulses after it entered.
  logic [BW-1:0] chain [BH];
  always @(posedge confclk) begin
    chain[0] <= cbitin;
    for (int i = 1; i < BH; i++) chain[i] <= chain[i-1];
  end
  assign cbitout = chain[BH-1];

  always @(posedge confclk) pulses <= pulses + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_xfer(input logic we, input logic [2:0] off, input logic [31:0] wd,
                         input logic [3:0] sel, output logic [31:0] rd);
    int n;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = {27'd0, off, 2'b00};
    wbs_dat_i = wd;
    wbs_sel_i = sel;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (wbs_ack_o !== 1'b1 && n < 8);
    check("wb_ack", 32'(wbs_ack_o), 32'd1);
    rd = wbs_dat_o;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  function automatic logic [15:0] word_of(input int i);
    return 16'(32'h1357 + 32'(i) * 32'h0F01);
  endfunction

  initial begin
    logic [31:0] rd;
    int p0;
    int n;
    wb_rst_i  = 1'b1;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'h0;
    wbs_dat_i = '0;
    wbs_adr_i = '0;
    uout      = '0;
    tick(2);
    wb_rst_i = 1'b0;

    // Reset state
    check("rst_reset", 32'(reset), 32'd1);
    check("rst_confclk", 32'(confclk), 32'd0);
    check("rst_cbitin", 32'(cbitin), 32'd0);
    check("rst_uin", 32'(uin), 32'd0);
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_dat", wbs_dat_o, 32'd0);
    wb_xfer(1'b0, OFF_STATUS, 32'd0, 4'hF, rd);
    check("rst_status", rd, 32'd0);

    // Single row: confclk rises PHASE+1 cycles after the CONF ack and lasts PHASE cycles
    wb_xfer(1'b1, OFF_CTRL, 32'd0, 4'hF, rd);
    check("ctrl_reset_low", 32'(reset), 32'd0);
    wb_xfer(1'b1, OFF_CONF, 32'hFFFF_A5C3, 4'hF, rd);
    for (int k = 1; k <= 2*PH + 1; k++) begin
      tick(1);
      check("row1_confclk", 32'(confclk), (k > PH && k <= 2*PH) ? 32'd1 : 32'd0);
      if (k == 1 || k == 2*PH + 1) check("row1_cbitin", 32'(cbitin), 32'h0000_A5C3);
    end
    tick(PH + 2);
    wb_xfer(1'b0, OFF_STATUS, 32'd0, 4'hF, rd);
    check("row1_status", rd, 32'h0000_0100);

    // Full load through the chain stub, then one more row to see row count saturate
    wb_xfer(1'b1, OFF_STATUS, 32'd0, 4'hF, rd);
    for (int i = 0; i < BH; i++) begin
      wb_xfer(1'b1, OFF_CONF, 32'(word_of(i)), 4'hF, rd);
      tick(3*PH + 2);
    end
    wb_xfer(1'b0, OFF_STATUS, 32'd0, 4'hF, rd);
    check("full_status", rd, 32'h0000_1002);
    check("full_cbitin", 32'(cbitin), 32'(word_of(BH - 1)));
    wb_xfer(1'b1, OFF_CONF, 32'h0000_FFFF, 4'hF, rd);
    tick(3*PH + 2);
    wb_xfer(1'b0, OFF_CAPT, 32'd0, 4'hF, rd);
    check("full_capt", rd, 32'(word_of(0)));
    wb_xfer(1'b0, OFF_STATUS, 32'd0, 4'hF, rd);
    check("sat_status", rd, 32'h0000_1002);

    // Overflow: hold the array in reset so nothing pops, then overfill the queue
    wb_xfer(1'b1, OFF_STATUS, 32'd0, 4'hF, rd);
    wb_xfer(1'b1, OFF_CTRL, 32'd1, 4'hF, rd);
    p0 = pulses;
    for (int i = 0; i < int'(QUEUE_DEPTH) + 2; i++)
      wb_xfer(1'b1, OFF_CONF, 32'h0000_C000 + 32'(i), 4'hF, rd);
    wb_xfer(1'b0, OFF_STATUS, 32'd0, 4'hF, rd);
    check("ovf_status", rd, 32'(QUEUE_DEPTH << 4) | 32'h5);
    check("ovf_no_pulse", 32'(pulses - p0), 32'd0);
    wb_xfer(1'b1, OFF_CTRL, 32'd0, 4'hF, rd);
    tick(int'(QUEUE_DEPTH) * (3*PH + 1) + 10);
    check("ovf_pulses", 32'(pulses - p0), 32'(QUEUE_DEPTH));
    check("ovf_last_cbitin", 32'(cbitin), 32'h0000_C000 + 32'(QUEUE_DEPTH - 1));
    wb_xfer(1'b0, OFF_STATUS, 32'd0, 4'hF, rd);
    check("ovf_status_after", rd, 32'(QUEUE_DEPTH << 8) | 32'h4);

    // Abort during HIGH of the second row with a third word waiting
    wb_xfer(1'b1, OFF_STATUS, 32'd0, 4'hF, rd);
    wb_xfer(1'b1, OFF_CONF, 32'h0000_AAAA, 4'hF, rd);
    tick(3*PH + 2);
    wb_xfer(1'b1, OFF_CONF, 32'h0000_BBBB, 4'hF, rd);
    wb_xfer(1'b1, OFF_CONF, 32'h0000_CCCC, 4'hF, rd);
    n = 0;
    while (confclk !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    check("abort_in_high", 32'(confclk), 32'd1);
    check("abort_cbitin", 32'(cbitin), 32'h0000_BBBB);
    wb_xfer(1'b1, OFF_CTRL, 32'd1, 4'hF, rd);
    tick(1);
    check("abort_confclk", 32'(confclk), 32'd0);
    p0 = pulses;
    wb_xfer(1'b0, OFF_STATUS, 32'd0, 4'hF, rd);
    check("abort_status", rd, 32'h0000_0100);
    tick(30);
    check("abort_no_pulse", 32'(pulses - p0), 32'd0);
    check("abort_reset", 32'(reset), 32'd1);

    // UIN byte selects, UOUT live read, unmapped offsets
    wb_xfer(1'b1, OFF_UIN, 32'hDEAD_BEEF, 4'b0011, rd);
    check("uin_low", 32'(uin), 32'h0000_BEEF);
    wb_xfer(1'b1, OFF_UIN, 32'hCAFE_F00D, 4'b1100, rd);
    check("uin_high", 32'(uin), 32'hCAFE_BEEF);
    wb_xfer(1'b0, OFF_UIN, 32'd0, 4'hF, rd);
    check("uin_read", rd, 32'hCAFE_BEEF);
    uout = 32'h1234_5678;
    wb_xfer(1'b0, OFF_UOUT, 32'd0, 4'hF, rd);
    check("uout_read", rd, 32'h1234_5678);
    wb_xfer(1'b1, 3'd7, 32'hFFFF_FFFF, 4'hF, rd);
    wb_xfer(1'b0, 3'd7, 32'd0, 4'hF, rd);
    check("unmapped_read", rd, 32'd0);
    wb_xfer(1'b0, OFF_CTRL, 32'd0, 4'hF, rd);
    check("ctrl_read", rd, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
